alu_ctrl_md: RTL and testbench
==============================

ALU_CTRL_MD -- requirements
Module: alu_ctrl_md

Interface
REQ-001 XLEN, default 32, datapath width for operands and result (legal values 8..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 inst  input  32  EX-stage instruction word: funct3 = inst[14:12], inst[30], inst[25].
REQ-005 alu_op  input  2  main-decoder class: 00 add, 01 sub, 10 R-type, 11 I-type arithmetic.
REQ-006 valid  input  1  inst, alu_op and operands are a live EX-stage instruction.
REQ-007 op_a, op_b  input  XLEN each  rs1 and rs2 operand values.
REQ-008 alu_sel  output  4  ALU operation select; combinational.
REQ-009 md_busy  output  1  pipeline stall request for a multiply/divide in progress.
REQ-010 md_done  output  1  one-cycle pulse; md_result valid.
REQ-011 md_result  output  XLEN  multiply/divide result; registered, held until the next md_done.

Function
REQ-012 alu_sel SHALL decode as: alu_op 00 -> 0010; alu_op 01 -> 0110; alu_op 10/11 by funct3: 000 -> 0010, or 0110 only when alu_op=10 and inst[30]=1; 001 -> 0100; 010 -> 1000; 011 -> 1001; 100 -> 0011; 101 -> 0101, or 0111 when inst[30]=1; 110 -> 0001; 111 -> 0000.
REQ-013 md_op = (alu_op==10 && inst[25]==1); when md_op, alu_sel SHALL be 1111 regardless of funct3.
REQ-014 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-015 IDLE->BUSY on valid && md_op; same edge latches op_a, op_b and funct3 and clears the iteration counter.
REQ-016 BUSY SHALL perform one shift-add (MUL*) or restoring-divide (DIV*/REM*) step per cycle on operand magnitudes, XLEN steps total, then go to DONE.
REQ-017 DONE SHALL assert md_done, load md_result with the sign-corrected value, and return to IDLE on the next edge.
REQ-018 md_busy = valid && md_op && state!=DONE, combinationally, so the start cycle itself stalls.
REQ-019 Latency: start edge at cycle N -> md_done high in cycle N+XLEN+1; md_busy is high in cycles N..N+XLEN.
REQ-020 Changes to inputs during BUSY SHALL be ignored; only latched values are used.
REQ-021 funct3 SHALL select: 000 MUL low half; 001 MULH s×s high; 010 MULHSU s×u high; 011 MULHU u×u high; 100 DIV; 101 DIVU; 110 REM; 111 REMU.
REQ-022 Divide by zero: quotient all ones, remainder = dividend, full latency.
REQ-023 Signed overflow (most negative / -1): quotient = most negative, remainder 0, full latency.
REQ-024 Signed remainder SHALL take the sign of the dividend; quotient truncates toward zero.
REQ-025 In DONE, the still-present valid && md_op SHALL NOT restart; a new start is possible only from IDLE.

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE and clear the counter, md_done and md_result to 0, including mid-operation.
REQ-027 During reset, md_busy SHALL follow REQ-018 on the reset state (IDLE); alu_sel stays combinational.

Configuration
REQ-028 Macro ALU_CTRL_MD_DIV_EN defined: divide/remainder ops are implemented per REQ-016, REQ-022, REQ-023 and REQ-024.
REQ-029 Macro absent: funct3 1xx goes IDLE->DONE directly, md_result = all ones, md_busy high only in the start cycle; no divider logic is synthesised; MUL* is unchanged.

Verification
REQ-030 Decode: alu_op=10, funct3=111, inst[25]=0 -> alu_sel 0000; alu_op=10, funct3=000, inst[30]=1 -> 0110; alu_op=11, funct3=101, inst[30]=1 -> 0111; alu_op=11, funct3=000, inst[30]=1 -> 0010.
REQ-031 MUL 7 × 0xFFFFFFFD with valid held -> md_result 0xFFFFFFEB, md_done in cycle N+33, md_busy high for exactly 33 cycles.
REQ-032 MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH on the same operands -> 0x00000000; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
REQ-033 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; with ALU_CTRL_MD_DIV_EN undefined, DIV 6/3 -> 0xFFFFFFFF in cycle N+1.
REQ-035 rst_n low at BUSY step 10 -> next cycle IDLE with md_done 0 and md_result 0; a following MUL 3×4 -> 12 at full latency.

Source files
------------

// File: rtl/alu_ctrl_md.sv
// EX-stage ALU control decoder with an iterative multiply/divide unit (one step per cycle).
// Define ALU_CTRL_MD_DIV_EN to build the restoring divider; otherwise DIV*/REM* return all ones.
module alu_ctrl_md #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst,
  input  logic [1:0]      alu_op,
  input  logic            valid,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      alu_sel,
  output logic            md_busy,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  logic [2:0] funct3;
  logic       md_op;
  logic       unused_inst;

  assign funct3      = inst[14:12];
  assign md_op       = (alu_op == 2'b10) && inst[25];
  assign unused_inst = ^{inst[31], inst[29:26], inst[24:15], inst[11:0]};

  always_comb begin
    alu_sel = 4'b0010;
    if (md_op) begin
      alu_sel = 4'b1111;
    end else begin
      case (alu_op)
        2'b00:   alu_sel = 4'b0010;
        2'b01:   alu_sel = 4'b0110;
        default: begin
          unique case (funct3)
            3'b000: alu_sel = (alu_op == 2'b10 && inst[30]) ? 4'b0110 : 4'b0010;
            3'b001: alu_sel = 4'b0100;
            3'b010: alu_sel = 4'b1000;
            3'b011: alu_sel = 4'b1001;
            3'b100: alu_sel = 4'b0011;
            3'b101: alu_sel = inst[30] ? 4'b0111 : 4'b0101;
            3'b110: alu_sel = 4'b0001;
            3'b111: alu_sel = 4'b0000;
            default: alu_sel = 4'b0000;
          endcase
        end
      endcase
    end
  end

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic            neg_q;
`ifdef ALU_CTRL_MD_DIV_EN
  logic [2:0]      f3_q;
  logic            rneg_q;
`else
  logic [1:0]      f3_q;
`endif

  assign md_busy = valid && md_op && (state_q != StDone);

  // Operand conditioning at the start edge: magnitudes plus the sign fix-up to apply at the end.
  logic            signed_a, signed_b, a_neg, b_neg, is_div, b_zero, direct_done;
  logic [XLEN-1:0] a_mag, b_mag, lo_init, opnd_init;
  logic            neg_init;

  always_comb begin
    signed_a  = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
    signed_b  = funct3[2] ? !funct3[0] : !funct3[1];
    a_neg     = signed_a && op_a[XLEN-1];
    b_neg     = signed_b && op_b[XLEN-1];
    a_mag     = a_neg ? -op_a : op_a;
    b_mag     = b_neg ? -op_b : op_b;
    is_div    = funct3[2];
    b_zero    = (op_b == '0);
    // Multiplier sits in lo for MUL*, dividend in lo for DIV*/REM*.
    lo_init   = is_div ? a_mag : b_mag;
    opnd_init = is_div ? b_mag : a_mag;
    // Divide-by-zero quotient must stay all ones, so no negation there.
    neg_init  = (a_neg ^ b_neg) && !(is_div && b_zero);
`ifdef ALU_CTRL_MD_DIV_EN
    direct_done = 1'b0;
`else
    direct_done = is_div;
`endif
  end

  // One iteration step; res_step is the final answer formed from the last step's outputs.
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   step_hi, step_lo, res_step;
  logic [2*XLEN-1:0] prod, prod_fix;
`ifdef ALU_CTRL_MD_DIV_EN
  logic [XLEN:0]     r_sh, diff;
`endif

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    step_hi  = mul_sum[XLEN:1];
    step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;
    res_step = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef ALU_CTRL_MD_DIV_EN
    r_sh = {hi_q, lo_q[XLEN-1]};
    diff = r_sh - {1'b0, opnd_q};
    if (f3_q[2]) begin
      if (!diff[XLEN]) begin
        step_hi = diff[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = r_sh[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end
      unique case (f3_q[1:0])
        2'b00:   res_step = neg_q ? -step_lo : step_lo;
        2'b01:   res_step = step_lo;
        2'b10:   res_step = rneg_q ? -step_hi : step_hi;
        default: res_step = step_hi;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      md_done   <= 1'b0;
      md_result <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
`ifdef ALU_CTRL_MD_DIV_EN
      rneg_q    <= 1'b0;
`endif
    end else begin
      md_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (valid && md_op) begin
            if (direct_done) begin
              state_q   <= StDone;
              md_done   <= 1'b1;
              md_result <= '1;
            end else begin
              state_q <= StBusy;
              cnt_q   <= '0;
              hi_q    <= '0;
              lo_q    <= lo_init;
              opnd_q  <= opnd_init;
              f3_q    <= funct3[$bits(f3_q)-1:0];
              neg_q   <= neg_init;
`ifdef ALU_CTRL_MD_DIV_EN
              rneg_q  <= a_neg;
`endif
            end
          end
        end
        StBusy: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) begin
            state_q   <= StDone;
            md_done   <= 1'b1;
            md_result <= res_step;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Bench for alu_ctrl_md: decode table, multiply/divide table with scoreboard, mid-op reset.
module tb_alu_ctrl_md;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     inst;
  logic [1:0]      alu_op;
  logic            valid;
  logic [XLEN-1:0] op_a, op_b;
  logic [3:0]      alu_sel;
  logic            md_busy, md_done;
  logic [XLEN-1:0] md_result;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  alu_ctrl_md #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .alu_op(alu_op), .valid(valid),
    .op_a(op_a), .op_b(op_b), .alu_sel(alu_sel), .md_busy(md_busy),
    .md_done(md_done), .md_result(md_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic       b30;
    logic       b25;
    logic [3:0] sel;
  } dec_t;

  typedef struct {
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
  } md_t;

  dec_t dv[16];
  md_t  mv[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic b30, input logic b25);
    logic [31:0] r;
    r        = $urandom;
    r[14:12] = f3;
    r[30]    = b30;
    r[25]    = b25;
    return r;
  endfunction

  // Start one op with valid held, scramble inputs while busy, then check timing and result.
  task automatic run_md(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp);
    int lat, busy_cnt, exp_lat;
    bit seen;
    logic [XLEN-1:0] exp_res, got;
    string tag;
    exp_res = exp;
    exp_lat = XLEN + 1;
`ifndef ALU_CTRL_MD_DIV_EN
    if (f3[2]) begin
      exp_res = '1;
      exp_lat = 1;
    end
`endif
    tag = $sformatf("f3=%0d a=%0h b=%0h", f3, a, b);
    @(negedge clk);
    inst   = mk_inst(f3, 1'($urandom_range(0, 1)), 1'b1);
    alu_op = 2'b10;
    op_a   = a;
    op_b   = b;
    valid  = 1'b1;
    exp_q.push_back(exp_res);
    lat = 0; busy_cnt = 0; seen = 0;
    while (lat <= 200) begin
      #1;
      if (md_done) begin
        seen = 1;
        break;
      end
      if (md_busy) busy_cnt++;
      @(negedge clk);
      lat++;
      op_a = $urandom;
      op_b = $urandom;
      inst = mk_inst(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
    end
    got = md_result;
    exp_res = exp_q.pop_front();
    check({tag, " md_done seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, " result"}, 64'(got), 64'(exp_res));
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
      check({tag, " busy in done"}, 64'(md_busy), 64'd0);
      check({tag, " alu_sel md"}, 64'(alu_sel), 64'hf);
    end
    valid = 1'b0;
    @(negedge clk);
    #1;
    check({tag, " done pulse ends"}, 64'(md_done), 64'd0);
    check({tag, " result held"}, 64'(md_result), 64'(exp_res));
  endtask

  initial begin
    dv[0]  = '{2'b00, 3'b101, 1'b1, 1'b1, 4'b0010};
    dv[1]  = '{2'b01, 3'b000, 1'b0, 1'b1, 4'b0110};
    dv[2]  = '{2'b10, 3'b000, 1'b0, 1'b0, 4'b0010};
    dv[3]  = '{2'b10, 3'b000, 1'b1, 1'b0, 4'b0110};
    dv[4]  = '{2'b11, 3'b000, 1'b1, 1'b0, 4'b0010};
    dv[5]  = '{2'b10, 3'b001, 1'b0, 1'b0, 4'b0100};
    dv[6]  = '{2'b11, 3'b010, 1'b0, 1'b0, 4'b1000};
    dv[7]  = '{2'b10, 3'b011, 1'b0, 1'b0, 4'b1001};
    dv[8]  = '{2'b11, 3'b100, 1'b0, 1'b0, 4'b0011};
    dv[9]  = '{2'b11, 3'b101, 1'b0, 1'b0, 4'b0101};
    dv[10] = '{2'b11, 3'b101, 1'b1, 1'b0, 4'b0111};
    dv[11] = '{2'b10, 3'b110, 1'b0, 1'b0, 4'b0001};
    dv[12] = '{2'b10, 3'b111, 1'b0, 1'b0, 4'b0000};
    dv[13] = '{2'b10, 3'b011, 1'b1, 1'b1, 4'b1111};
    dv[14] = '{2'b11, 3'b000, 1'b0, 1'b1, 4'b0010};
    dv[15] = '{2'b10, 3'b111, 1'b0, 1'b1, 4'b1111};

    mv[0]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    mv[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    mv[2]  = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    mv[3]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    mv[4]  = '{3'b011, 32'h80000000, 32'h00000002, 32'h00000001};
    mv[5]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
    mv[6]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
    mv[7]  = '{3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF};
    mv[8]  = '{3'b111, 32'h00000005, 32'h00000000, 32'h00000005};
    mv[9]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    mv[10] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    mv[11] = '{3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF};
    mv[12] = '{3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9};
    mv[13] = '{3'b101, 32'd100,      32'd7,        32'd14};
    mv[14] = '{3'b111, 32'd100,      32'd7,        32'd2};
    mv[15] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1};
    mv[16] = '{3'b100, 32'd6,        32'd3,        32'd2};
    mv[17] = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};

    rst_n = 1'b0; valid = 1'b0; alu_op = 2'b00; inst = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset md_done", 64'(md_done), 64'd0);
    check("reset md_result", 64'(md_result), 64'd0);
    check("reset md_busy", 64'(md_busy), 64'd0);
    rst_n = 1'b1;

    foreach (dv[i]) begin
      @(negedge clk);
      inst   = mk_inst(dv[i].f3, dv[i].b30, dv[i].b25);
      alu_op = dv[i].op;
      #1;
      check($sformatf("decode %0d alu_sel", i), 64'(alu_sel), 64'(dv[i].sel));
    end
    alu_op = 2'b00;

    foreach (mv[i]) run_md(mv[i].f3, mv[i].a, mv[i].b, mv[i].res);

    // Abort a MULHU mid-flight, probe busy on the reset state, then rerun a multiply.
    @(negedge clk);
    inst = mk_inst(3'b011, 1'b0, 1'b1); alu_op = 2'b10;
    op_a = '1; op_b = '1; valid = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0; valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid-op reset md_done", 64'(md_done), 64'd0);
    check("mid-op reset md_result", 64'(md_result), 64'd0);
    check("mid-op reset md_busy idle", 64'(md_busy), 64'd0);
    valid = 1'b1;
    #1;
    check("md_busy during reset", 64'(md_busy), 64'd1);
    @(negedge clk);
    valid = 1'b0;
    #1;
    check("reset held md_done", 64'(md_done), 64'd0);
    rst_n = 1'b1;
    run_md(3'b000, 32'd3, 32'd4, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
